// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator dispatcher slice.
//   - FSM state encoding (IDLE / MOVING / DOOR_OPEN)
//   - floor index width and request vector width
//   - SCAN direction constants
//   - helper that turns a floor index into a one-hot clear vector
package elevator_pkg;

    localparam int FLOOR_W = 4;
    localparam int REQ_W   = 10;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_MOVING    = 2'd1;
    localparam logic [1:0] ST_DOOR_OPEN = 2'd2;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    function automatic logic [REQ_W-1:0] floor_onehot(input logic [FLOOR_W-1:0] f);
        return REQ_W'(1) << f;
    endfunction

endpackage

// File: rtl/elevator_request_scan.sv
// Combinational scan of the request vector relative to one floor.
// Ports:
//   request_i [REQ_W-1:0]   pending floor requests (bits >= FLOORS ignored)
//   floor_i   [FLOOR_W-1:0] reference floor
//   here_o                  request pending at floor_i
//   above_o                 any request at an index above floor_i
//   below_o                 any request at an index below floor_i
module elevator_request_scan
    import elevator_pkg::*;
#(
    parameter int FLOORS = 10
) (
    input  logic [REQ_W-1:0]   request_i,
    input  logic [FLOOR_W-1:0] floor_i,
    output logic               here_o,
    output logic               above_o,
    output logic               below_o
);

    always_comb begin
        here_o  = 1'b0;
        above_o = 1'b0;
        below_o = 1'b0;
        for (int i = 0; i < REQ_W; i++) begin
            // Bits past the top floor do not exist in this building.
            if ((i < FLOORS) && request_i[i]) begin
                if (FLOOR_W'(i) == floor_i) begin
                    here_o = 1'b1;
                end else if (FLOOR_W'(i) > floor_i) begin
                    above_o = 1'b1;
                end else begin
                    below_o = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/elevator_dispatcher.sv
// Elevator dispatcher: consumes held floor requests, selects stops with SCAN
// (keep direction while work remains ahead), moves one floor every
// TRAVEL_CYCLES, dwells DOOR_CYCLES with the door open and retires the
// request of the current floor through a one-hot clear.
// Ports:
//   clock          system clock, all logic on posedge
//   reset          synchronous active-high reset
//   request [9:0]  request[i]=1 while floor i is pending
//   clear   [9:0]  clear[i]=1 retires floor i (only during the door dwell)
//   current_floor  floor the car is at or last passed
//   direction      1=up, 0=down
//   moving         1 while in MOVING
//   door_open      1 while in DOOR_OPEN
// Handshake: request[i] is held by the detector until clear[i] is seen; clear
// stays high for the full dwell so any re-press during the dwell is absorbed.
module elevator_dispatcher
    import elevator_pkg::*;
#(
    parameter int FLOORS        = 10,
    parameter int TRAVEL_CYCLES = 4,
    parameter int DOOR_CYCLES   = 6
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [REQ_W-1:0]    request,
    output logic [REQ_W-1:0]    clear,
    output logic [FLOOR_W-1:0]  current_floor,
    output logic                direction,
    output logic                moving,
    output logic                door_open
);

    localparam int TW = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
    localparam int DW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
    localparam logic [TW-1:0]      TRAVEL_LOAD = TW'(TRAVEL_CYCLES - 1);
    localparam logic [DW-1:0]      DOOR_LOAD   = DW'(DOOR_CYCLES - 1);
    localparam logic [FLOOR_W-1:0] TOP_FLOOR   = FLOOR_W'(FLOORS - 1);

    logic [1:0]         state_q, state_d;
    logic [FLOOR_W-1:0] floor_q, floor_d;
    logic               dir_q, dir_d;
    logic [REQ_W-1:0]   clear_q, clear_d;
    logic               moving_q, moving_d;
    logic               door_open_q, door_open_d;
    logic [TW-1:0]      travel_q, travel_d;
    logic [DW-1:0]      door_q, door_d;

    logic [FLOOR_W-1:0] next_floor;
    logic               here, above, below;
    logic               n_here, n_above, n_below;
    logic               at_limit;

    // Floor the car reaches when the travel timer expires.
    assign next_floor = (dir_q == DIR_UP) ? (floor_q + FLOOR_W'(1)) : (floor_q - FLOOR_W'(1));

    // Only reachable if the requests ahead vanished mid-travel; never step
    // outside the shaft.
    assign at_limit = ((dir_q == DIR_UP) && (floor_q == TOP_FLOOR)) ||
                      ((dir_q == DIR_DOWN) && (floor_q == '0));

    elevator_request_scan #(.FLOORS(FLOORS)) u_scan_cur (
        .request_i (request),
        .floor_i   (floor_q),
        .here_o    (here),
        .above_o   (above),
        .below_o   (below)
    );

    elevator_request_scan #(.FLOORS(FLOORS)) u_scan_next (
        .request_i (request),
        .floor_i   (next_floor),
        .here_o    (n_here),
        .above_o   (n_above),
        .below_o   (n_below)
    );

    always_comb begin
        state_d     = state_q;
        floor_d     = floor_q;
        dir_d       = dir_q;
        clear_d     = '0;
        moving_d    = 1'b0;
        door_open_d = 1'b0;
        travel_d    = travel_q;
        door_d      = door_q;

        case (state_q)
            ST_IDLE: begin
                if (here) begin
                    state_d     = ST_DOOR_OPEN;
                    door_d      = DOOR_LOAD;
                    door_open_d = 1'b1;
                    clear_d     = floor_onehot(floor_q);
                end else if (((dir_q == DIR_UP) && above) || ((dir_q == DIR_DOWN) && below)) begin
                    state_d  = ST_MOVING;
                    moving_d = 1'b1;
                    travel_d = TRAVEL_LOAD;
                end else if (above) begin
                    dir_d    = DIR_UP;
                    state_d  = ST_MOVING;
                    moving_d = 1'b1;
                    travel_d = TRAVEL_LOAD;
                end else if (below) begin
                    dir_d    = DIR_DOWN;
                    state_d  = ST_MOVING;
                    moving_d = 1'b1;
                    travel_d = TRAVEL_LOAD;
                end
            end

            ST_MOVING: begin
                if (travel_q != '0) begin
                    travel_d = travel_q - TW'(1);
                    moving_d = 1'b1;
                end else if (at_limit) begin
                    state_d = ST_IDLE;
                end else begin
                    // Arrival decision uses the request vector seen at the
                    // floor being entered, so pass-by requests are served.
                    floor_d = next_floor;
                    if (n_here) begin
                        state_d     = ST_DOOR_OPEN;
                        door_d      = DOOR_LOAD;
                        door_open_d = 1'b1;
                        clear_d     = floor_onehot(next_floor);
                    end else if (((dir_q == DIR_UP) && n_above) ||
                                 ((dir_q == DIR_DOWN) && n_below)) begin
                        moving_d = 1'b1;
                        travel_d = TRAVEL_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end

            ST_DOOR_OPEN: begin
                if (door_q != '0) begin
                    door_d      = door_q - DW'(1);
                    door_open_d = 1'b1;
                    clear_d     = clear_q;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            floor_q     <= '0;
            dir_q       <= DIR_UP;
            clear_q     <= '0;
            moving_q    <= 1'b0;
            door_open_q <= 1'b0;
            travel_q    <= '0;
            door_q      <= '0;
        end else begin
            state_q     <= state_d;
            floor_q     <= floor_d;
            dir_q       <= dir_d;
            clear_q     <= clear_d;
            moving_q    <= moving_d;
            door_open_q <= door_open_d;
            travel_q    <= travel_d;
            door_q      <= door_d;
        end
    end

    assign clear         = clear_q;
    assign current_floor = floor_q;
    assign direction     = dir_q;
    assign moving        = moving_q;
    assign door_open     = door_open_q;

endmodule

// File: tb/tb_elevator_dispatcher.sv
// Bench for elevator_dispatcher: hand-written timing sequences plus a table of
// SCAN scenarios. Expected stop floors are queued when requests are raised
// and popped when the DUT raises a new clear.
module tb_elevator_dispatcher;

    localparam int DOOR_CYC = 6;

    logic       clock;
    logic       reset;
    logic [9:0] request;
    logic [9:0] clear;
    logic [3:0] current_floor;
    logic       direction;
    logic       moving;
    logic       door_open;

    logic [9:0] request8;
    logic [9:0] clear8;
    logic [3:0] floor8;
    logic       dir8;
    logic       moving8;
    logic       door8;

    int checks = 0;
    int errors = 0;

    logic [3:0] exp_q[$];

    typedef struct {
        logic [9:0] req_a;
        int         wait_cyc;
        logic [9:0] req_b;
        logic [9:0] drop;
        int         s0;
        int         s1;
        logic [3:0] exp_floor;
        logic       exp_dir;
    } vec_t;

    vec_t vecs[9];

    elevator_dispatcher dut (
        .clock         (clock),
        .reset         (reset),
        .request       (request),
        .clear         (clear),
        .current_floor (current_floor),
        .direction     (direction),
        .moving        (moving),
        .door_open     (door_open)
    );

    elevator_dispatcher #(.FLOORS(8)) dut8 (
        .clock         (clock),
        .reset         (reset),
        .request       (request8),
        .clear         (clear8),
        .current_floor (floor8),
        .direction     (dir8),
        .moving        (moving8),
        .door_open     (door8)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock; afterwards the request detectors drop any bit they saw cleared.
    task automatic step();
        @(posedge clock);
        #1;
        request  = request & ~clear;
        request8 = request8 & ~clear8;
    endtask

    task automatic wait_idle(input int max_cyc, input string name);
        bit done;
        done = 1'b0;
        for (int k = 0; k < max_cyc && !done; k++) begin
            step();
            if (!moving && !door_open && request == 10'd0) done = 1'b1;
        end
        check(name, 32'(done), 32'd1);
    endtask

    // ---------------- scoreboard / monitor ----------------
    logic [9:0] prev_clear;
    int         dwell;

    always @(negedge clock) begin
        if (reset) begin
            prev_clear = '0;
            dwell      = 0;
        end else begin
            check("floor_range", 32'(current_floor < 4'd10), 32'd1);
            check("clear_legal",
                  32'((clear == 10'd0) ||
                      (door_open && clear == (10'd1 << current_floor))), 32'd1);
            if (clear != 10'd0 && prev_clear == 10'd0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_stop", 32'(current_floor), 32'hFFFF);
                end else begin
                    check("stop_floor", 32'(current_floor), 32'(exp_q.pop_front()));
                end
            end
            if (door_open) begin
                dwell++;
            end else if (dwell != 0) begin
                check("door_dwell", 32'(dwell), 32'(DOOR_CYC));
                dwell = 0;
            end
            prev_clear = clear;
        end
    end

    // ---------------- test ----------------
    initial begin
        vecs[0] = '{10'h022, 0,  10'h000, 10'h000, 5, 1,  4'd1, 1'b0};
        vecs[1] = '{10'h001, 0,  10'h000, 10'h000, 0, -1, 4'd0, 1'b0};
        vecs[2] = '{10'h080, 10, 10'h010, 10'h000, 4, 7,  4'd7, 1'b1};
        vecs[3] = '{10'h200, 0,  10'h000, 10'h000, 9, -1, 4'd9, 1'b1};
        vecs[4] = '{10'h040, 0,  10'h000, 10'h000, 6, -1, 4'd6, 1'b0};
        vecs[5] = '{10'h104, 0,  10'h000, 10'h000, 2, 8,  4'd8, 1'b1};
        vecs[6] = '{10'h008, 2,  10'h200, 10'h000, 3, 9,  4'd9, 1'b1};
        vecs[7] = '{10'h024, 6,  10'h000, 10'h020, 2, -1, 4'd2, 1'b0};
        vecs[8] = '{10'h004, 0,  10'h000, 10'h000, 2, -1, 4'd2, 1'b0};

        reset    = 1'b1;
        request  = '0;
        request8 = '0;
        repeat (3) step();
        reset = 1'b0;
        step();
        check("rst_floor", 32'(current_floor), 32'd0);
        check("rst_dir", 32'(direction), 32'd1);
        check("rst_clear", 32'(clear), 32'd0);
        check("rst_moving", 32'(moving), 32'd0);
        check("rst_door", 32'(door_open), 32'd0);

        // Request at the current floor: door one edge later, 6-cycle dwell.
        exp_q.push_back(4'd0);
        request = 10'h001;
        step();
        check("here_door", 32'(door_open), 32'd1);
        check("here_clear", 32'(clear), 32'h001);
        repeat (5) step();
        check("here_door_last", 32'(door_open), 32'd1);
        step();
        check("here_closed", 32'(door_open), 32'd0);
        check("here_clear_off", 32'(clear), 32'd0);
        check("here_idle", 32'(moving), 32'd0);

        // Travel 0 -> 3 at 4 cycles per floor.
        exp_q.push_back(4'd3);
        request = request | 10'h008;
        step();
        check("mv_start", 32'(moving), 32'd1);
        check("mv_dir", 32'(direction), 32'd1);
        repeat (3) step();
        check("mv_f0", 32'(current_floor), 32'd0);
        step();
        check("mv_f1", 32'(current_floor), 32'd1);
        repeat (4) step();
        check("mv_f2", 32'(current_floor), 32'd2);
        repeat (4) step();
        check("mv_f3", 32'(current_floor), 32'd3);
        check("mv_arrive_door", 32'(door_open), 32'd1);
        check("mv_arrive_moving", 32'(moving), 32'd0);
        check("mv_arrive_clear", 32'(clear), 32'h008);
        wait_idle(100, "mv_idle");

        // Table-driven SCAN scenarios, each starting where the last ended.
        for (int v = 0; v < 9; v++) begin
            if (vecs[v].s0 >= 0) exp_q.push_back(4'(vecs[v].s0));
            if (vecs[v].s1 >= 0) exp_q.push_back(4'(vecs[v].s1));
            request = request | vecs[v].req_a;
            repeat (vecs[v].wait_cyc) step();
            request = (request | vecs[v].req_b) & ~vecs[v].drop;
            wait_idle(400, $sformatf("vec%0d_idle", v));
            check($sformatf("vec%0d_floor", v), 32'(current_floor), 32'(vecs[v].exp_floor));
            check($sformatf("vec%0d_dir", v), 32'(direction), 32'(vecs[v].exp_dir));
            check($sformatf("vec%0d_drained", v), 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end

        // Reset while moving past floor 5; held requests re-served from 0.
        request = request | 10'h100;
        repeat (14) step();
        check("rstmv_floor5", 32'(current_floor), 32'd5);
        check("rstmv_moving", 32'(moving), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rstmv_floor", 32'(current_floor), 32'd0);
        check("rstmv_moving_off", 32'(moving), 32'd0);
        check("rstmv_door", 32'(door_open), 32'd0);
        check("rstmv_clear", 32'(clear), 32'd0);
        check("rstmv_dir", 32'(direction), 32'd1);
        exp_q.push_back(4'd5);
        exp_q.push_back(4'd8);
        request = request | 10'h020;
        wait_idle(400, "rstmv_idle");
        check("rstmv_final", 32'(current_floor), 32'd8);
        check("rstmv_drained", 32'(exp_q.size()), 32'd0);

        // FLOORS=8 build: bits 8 and 9 never cause motion.
        request8 = 10'h300;
        repeat (20) step();
        check("f8_ignore_moving", 32'(moving8), 32'd0);
        check("f8_ignore_door", 32'(door8), 32'd0);
        check("f8_ignore_floor", 32'(floor8), 32'd0);
        check("f8_ignore_clear", 32'(clear8), 32'd0);
        request8 = request8 | 10'h008;
        begin
            bit seen;
            seen = 1'b0;
            for (int k = 0; k < 100 && !seen; k++) begin
                step();
                if (door8) seen = 1'b1;
            end
            check("f8_door_seen", 32'(seen), 32'd1);
        end
        check("f8_stop_floor", 32'(floor8), 32'd3);
        check("f8_stop_clear", 32'(clear8), 32'h008);
        repeat (30) step();
        check("f8_after_moving", 32'(moving8), 32'd0);
        check("f8_after_floor", 32'(floor8), 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
